vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//   Raster timing source for the Pong display path. Produces pixel coordinates hcount/vcount,
//   the active-video enable and hsync/vsync consumed by the game-object/layer pixel generators.
//   Runs from the 50 MHz board clock with an internal pixel-rate divider (640x480@60, 25 MHz).
//   Sync outputs are delayed to line up with the registered colour out of the pixel generators.
// PARAMETERS
//   CLK_DIV    2    clock cycles per pixel; legal range >=1 (1 = tick every cycle)
//   H_ACTIVE   640  visible pixels per line
//   H_FRONT    16   horizontal front porch (pixels)
//   H_SYNC     96   horizontal sync width (pixels)
//   H_BACK     48   horizontal back porch (pixels); H_TOTAL = sum = 800
//   V_ACTIVE   480  visible lines per frame
//   V_FRONT    10   vertical front porch (lines)
//   V_SYNC     2    vertical sync width (lines)
//   V_BACK     33   vertical back porch (lines); V_TOTAL = sum = 525
//   SYNC_POL   0    asserted sync level (0 = active-low, as 640x480 requires)
//   SYNC_DELAY 1    extra clock cycles applied to hsync/vsync only; legal range 0..7
// PORTS
//   clock        in   1   system clock, 50 MHz
//   reset        in   1   synchronous, active-high
//   hcount       out  10  pixel column, 0..H_TOTAL-1
//   vcount       out  10  line number, 0..V_TOTAL-1
//   enable       out  1   1 when hcount<H_ACTIVE and vcount<V_ACTIVE
//   pixel_tick   out  1   one-clock strobe, once per pixel period
//   line_start   out  1   one-clock strobe on the tick that sets hcount to 0
//   frame_start  out  1   one-clock strobe on the tick that sets hcount and vcount to 0
//   hsync        out  1   horizontal sync at SYNC_POL, delayed by SYNC_DELAY clocks
//   vsync        out  1   vertical sync at SYNC_POL, delayed by SYNC_DELAY clocks
// BEHAVIOUR
//   Reset (synchronous, every clock edge with reset=1):
//   - div_cnt=0, hcount=0, vcount=0, all strobes=0, enable=0.
//   - hsync/vsync = ~SYNC_POL, including every stage of the delay line.
//   - Reset wins over a simultaneous tick. Reset mid-frame restarts the raster at (0,0).
//   Divider:
//   - div_cnt counts 0..CLK_DIV-1 and wraps. pixel_tick=1 on the clock where div_cnt==CLK_DIV-1.
//   - The first tick is the CLK_DIV-th clock after reset is released.
//   Counters (registered; updated only on pixel_tick):
//   - hcount==H_TOTAL-1 -> hcount=0 and vcount increments.
//   - vcount==V_TOTAL-1 at that same point -> vcount=0.
//   - All width arithmetic is 10-bit; no value >= H_TOTAL or V_TOTAL is ever emitted.
//   Decode:
//   - enable, hsync_raw, vsync_raw, line_start and frame_start are computed from the next-count
//     values and registered in the same edge as the counters, so all of them align with hcount/vcount.
//   - Consequence: enable=1 on the first clock after reset is released (position 0,0 is active).
//   - line_start and frame_start are 1 for exactly one clock (the tick clock) and 0 otherwise.
//   Sync windows:
//   - hsync_raw asserted for hcount in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1] = [656,751].
//   - vsync_raw asserted for vcount in [490,491], over the whole of each of those lines.
//   - hsync/vsync = hsync_raw/vsync_raw passed through a SYNC_DELAY-deep shift register that
//     advances every clock (not every tick). SYNC_DELAY=0 connects them directly.
//   Per-axis phase FSM (one in each axis counter):
//   - States ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE, advancing on the tick where the counter
//     reaches the region end. The FSM drives the enable and sync decode.
//   - The FSM must agree with the count comparisons at every position; an illegal state recovers
//     to ACTIVE on the next counter wrap.
//   - The vertical FSM advances only when the horizontal counter wraps.
// STRUCTURE
//   - vga_pkg: VGA_640x480 timing constants (the 8 porch/sync/active values and H_TOTAL/V_TOTAL)
//     and the phase enum {PH_ACTIVE, PH_FRONT, PH_SYNC, PH_BACK}.
//   - Sub-module vga_axis_counter (params ACTIVE/FRONT/SYNC/BACK; inputs clock, reset, step;
//     outputs count, phase, wrap). Instantiated twice:
//     - horizontal: step = pixel_tick
//     - vertical: step = pixel_tick & horizontal wrap
//   - The top level holds the divider, the output registers and the sync delay line.
// TESTING
//   1 Reset, then run 2*800*525 clocks -> hcount wraps 799->0 once per line; vcount wraps 524->0
//     once per frame; frame_start pulses exactly twice, 840000 clocks apart.
//   2 Count one line -> hsync low for exactly 96 ticks (192 clocks), starting at hcount=656;
//     enable high for 640 ticks per visible line.
//   3 Count one frame -> vsync low for lines 490-491 only (1600 ticks); enable=0 for all of
//     lines 480..524.
//   4 SYNC_DELAY=3 -> hsync falls exactly 3 clocks after the clock where hcount becomes 656.
//   5 Assert reset at hcount=300, vcount=200 for 1 clock -> next clock hcount=0, vcount=0,
//     hsync=vsync=1; first tick 2 clocks after release; enable=1.
//   6 CLK_DIV=1 -> pixel_tick constantly 1; frame period = 420000 clocks.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared raster constants and phase encoding for the VGA timing path.
package vga_pkg;

    localparam int unsigned CNT_W = 10;

    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FRONT  = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BACK   = 48;
    localparam int unsigned VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FRONT  = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BACK   = 33;
    localparam int unsigned VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    typedef enum logic [1:0] {
        PH_ACTIVE,
        PH_FRONT,
        PH_SYNC,
        PH_BACK
    } phase_t;

    // Region a count falls in, from plain comparisons against the region bounds.
    function automatic phase_t phase_of(input logic [CNT_W-1:0] count,
                                        input int unsigned active,
                                        input int unsigned front,
                                        input int unsigned sync);
        int unsigned c;
        c = 32'(count);
        if (c < active)                return PH_ACTIVE;
        if (c < active + front)        return PH_FRONT;
        if (c < active + front + sync) return PH_SYNC;
        return PH_BACK;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus region-tracking phase FSM, both advanced on step.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int unsigned ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned FRONT  = VGA_H_FRONT,
    parameter int unsigned SYNC   = VGA_H_SYNC,
    parameter int unsigned BACK   = VGA_H_BACK
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             step,
    output logic [CNT_W-1:0] count,
    output phase_t           phase,
    output logic             wrap,
    output phase_t           phase_nxt_c
);

    localparam logic [CNT_W-1:0] ACT_END   = CNT_W'(ACTIVE - 1);
    localparam logic [CNT_W-1:0] FRONT_END = CNT_W'(ACTIVE + FRONT - 1);
    localparam logic [CNT_W-1:0] SYNC_END  = CNT_W'(ACTIVE + FRONT + SYNC - 1);
    localparam logic [CNT_W-1:0] LAST      = CNT_W'(ACTIVE + FRONT + SYNC + BACK - 1);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    phase_t           r_phase;
    phase_t           w_phase_nxt;

    assign wrap = (r_count == LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
            r_phase <= PH_ACTIVE;
        end else begin
            r_count <= w_count_nxt;
            r_phase <= w_phase_nxt;
        end
    end

    // Phase advances on the step that leaves the last position of its region.
    always_comb begin
        w_count_nxt = r_count;
        w_phase_nxt = r_phase;
        if (step) begin
            w_count_nxt = wrap ? '0 : r_count + CNT_W'(1);
            case (r_phase)
                PH_ACTIVE: if (r_count == ACT_END)   w_phase_nxt = PH_FRONT;
                PH_FRONT:  if (r_count == FRONT_END) w_phase_nxt = PH_SYNC;
                PH_SYNC:   if (r_count == SYNC_END)  w_phase_nxt = PH_BACK;
                PH_BACK:   if (wrap)                 w_phase_nxt = PH_ACTIVE;
                default:   if (wrap)                 w_phase_nxt = PH_ACTIVE;
            endcase
        end
    end

    assign count       = r_count;
    assign phase       = r_phase;
    assign phase_nxt_c = w_phase_nxt;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: pixel-rate divider, h/v axis counters, registered decode
// and a per-clock delay line that lines hsync/vsync up with downstream colour.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned H_ACTIVE   = VGA_H_ACTIVE,
    parameter int unsigned H_FRONT    = VGA_H_FRONT,
    parameter int unsigned H_SYNC     = VGA_H_SYNC,
    parameter int unsigned H_BACK     = VGA_H_BACK,
    parameter int unsigned V_ACTIVE   = VGA_V_ACTIVE,
    parameter int unsigned V_FRONT    = VGA_V_FRONT,
    parameter int unsigned V_SYNC     = VGA_V_SYNC,
    parameter int unsigned V_BACK     = VGA_V_BACK,
    parameter logic        SYNC_POL   = 1'b0,
    parameter int unsigned SYNC_DELAY = 1
) (
    input  logic             clock,
    input  logic             reset,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             enable,
    output logic             pixel_tick,
    output logic             line_start,
    output logic             frame_start,
    output logic             hsync,
    output logic             vsync
);

    localparam int unsigned      DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] r_div_cnt;
    logic [DIV_W-1:0] w_div_nxt;
    logic             w_tick;
    logic             w_v_step;
    logic             w_h_wrap;
    logic             w_v_wrap;
    phase_t           w_h_phase;
    phase_t           w_v_phase;
    phase_t           w_h_phase_nxt;
    phase_t           w_v_phase_nxt;

    logic r_pixel_tick;
    logic r_line_start;
    logic r_frame_start;
    logic r_enable;
    logic r_hsync_raw;
    logic r_vsync_raw;

    assign w_tick    = (r_div_cnt == DIV_LAST);
    assign w_div_nxt = w_tick ? '0 : r_div_cnt + DIV_W'(1);
    assign w_v_step  = w_tick & w_h_wrap;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK)
    ) u_h_axis (
        .clock      (clock),
        .reset      (reset),
        .step       (w_tick),
        .count      (hcount),
        .phase      (w_h_phase),
        .wrap       (w_h_wrap),
        .phase_nxt_c(w_h_phase_nxt)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK)
    ) u_v_axis (
        .clock      (clock),
        .reset      (reset),
        .step       (w_v_step),
        .count      (vcount),
        .phase      (w_v_phase),
        .wrap       (w_v_wrap),
        .phase_nxt_c(w_v_phase_nxt)
    );

    // Decode from next-state phases so every flag lands alongside the counts it describes.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_div_cnt     <= '0;
            r_pixel_tick  <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_enable      <= 1'b0;
            r_hsync_raw   <= ~SYNC_POL;
            r_vsync_raw   <= ~SYNC_POL;
        end else begin
            r_div_cnt     <= w_div_nxt;
            r_pixel_tick  <= (w_div_nxt == DIV_LAST);
            r_line_start  <= w_tick & w_h_wrap;
            r_frame_start <= w_v_step & w_v_wrap;
            r_enable      <= (w_h_phase_nxt == PH_ACTIVE) && (w_v_phase_nxt == PH_ACTIVE);
            r_hsync_raw   <= (w_h_phase_nxt == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
            r_vsync_raw   <= (w_v_phase_nxt == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
        end
    end

    generate
        if (SYNC_DELAY == 0) begin : g_no_dly
            assign hsync = r_hsync_raw;
            assign vsync = r_vsync_raw;
        end else begin : g_dly
            logic [SYNC_DELAY-1:0] r_hs_dly;
            logic [SYNC_DELAY-1:0] r_vs_dly;

            // Shifts every clock, not every tick, so the delay is in system clocks.
            always_ff @(posedge clock) begin
                if (reset) begin
                    r_hs_dly <= {SYNC_DELAY{~SYNC_POL}};
                    r_vs_dly <= {SYNC_DELAY{~SYNC_POL}};
                end else begin
                    r_hs_dly <= SYNC_DELAY'({r_hs_dly, r_hsync_raw});
                    r_vs_dly <= SYNC_DELAY'({r_vs_dly, r_vsync_raw});
                end
            end

            assign hsync = r_hs_dly[SYNC_DELAY-1];
            assign vsync = r_vs_dly[SYNC_DELAY-1];
        end
    endgenerate

    assign pixel_tick  = r_pixel_tick;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign enable      = r_enable;

    a_h_phase: assert property (@(posedge clock) disable iff (reset)
        w_h_phase == phase_of(hcount, H_ACTIVE, H_FRONT, H_SYNC));
    a_v_phase: assert property (@(posedge clock) disable iff (reset)
        w_v_phase == phase_of(vcount, V_ACTIVE, V_FRONT, V_SYNC));

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three configurations checked every cycle against a
// closed-form raster model, plus directed literal checks and random resets.
module tb_vga_timing_gen;

    localparam int unsigned SH_A = 16, SH_F = 2, SH_S = 4, SH_B = 3;
    localparam int unsigned SV_A = 10, SV_F = 2, SV_S = 2, SV_B = 3;

    typedef struct {
        int d; int sd; int pol;
        int ha; int hf; int hs; int hb;
        int va; int vf; int vs; int vb;
    } cfg_t;

    cfg_t cfg_a = '{d:2, sd:1, pol:0, ha:640, hf:16, hs:96, hb:48, va:480, vf:10, vs:2, vb:33};
    cfg_t cfg_b = '{d:1, sd:3, pol:0, ha:16, hf:2, hs:4, hb:3, va:10, vf:2, vs:2, vb:3};
    cfg_t cfg_c = '{d:3, sd:0, pol:1, ha:16, hf:2, hs:4, hb:3, va:10, vf:2, vs:2, vb:3};

    logic clk = 1'b0;
    logic rst_a;
    logic rst_bc;

    logic [9:0] hcount_a, vcount_a, hcount_b, vcount_b, hcount_c, vcount_c;
    logic en_a, pt_a, ls_a, fs_a, hs_a, vs_a;
    logic en_b, pt_b, ls_b, fs_b, hs_b, vs_b;
    logic en_c, pt_c, ls_c, fs_c, hs_c, vs_c;

    int k_a = -1;
    int k_bc = -1;
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vga_timing_gen dut_a (
        .clock(clk), .reset(rst_a), .hcount(hcount_a), .vcount(vcount_a), .enable(en_a),
        .pixel_tick(pt_a), .line_start(ls_a), .frame_start(fs_a), .hsync(hs_a), .vsync(vs_a)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(SH_A), .H_FRONT(SH_F), .H_SYNC(SH_S), .H_BACK(SH_B),
        .V_ACTIVE(SV_A), .V_FRONT(SV_F), .V_SYNC(SV_S), .V_BACK(SV_B),
        .SYNC_POL(1'b0), .SYNC_DELAY(3)
    ) dut_b (
        .clock(clk), .reset(rst_bc), .hcount(hcount_b), .vcount(vcount_b), .enable(en_b),
        .pixel_tick(pt_b), .line_start(ls_b), .frame_start(fs_b), .hsync(hs_b), .vsync(vs_b)
    );

    vga_timing_gen #(
        .CLK_DIV(3), .H_ACTIVE(SH_A), .H_FRONT(SH_F), .H_SYNC(SH_S), .H_BACK(SH_B),
        .V_ACTIVE(SV_A), .V_FRONT(SV_F), .V_SYNC(SV_S), .V_BACK(SV_B),
        .SYNC_POL(1'b1), .SYNC_DELAY(0)
    ) dut_c (
        .clock(clk), .reset(rst_bc), .hcount(hcount_c), .vcount(vcount_c), .enable(en_c),
        .pixel_tick(pt_c), .line_start(ls_c), .frame_start(fs_c), .hsync(hs_c), .vsync(vs_c)
    );

    // Clocks elapsed since the last reset edge; -1 until a reset has been seen.
    always @(posedge clk) begin
        if (rst_a) k_a <= 0;
        else if (k_a >= 0) k_a <= k_a + 1;
        if (rst_bc) k_bc <= 0;
        else if (k_bc >= 0) k_bc <= k_bc + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Raster position after T = k/d ticks, sync taken from k-sd clocks earlier.
    function automatic void model(input cfg_t c, input int k,
                                  output int e_h, output int e_v, output int e_en,
                                  output int e_pt, output int e_ls, output int e_fs,
                                  output int e_hs, output int e_vs);
        int htot, vtot, pos, ks, hk, vk, hw, vw;
        htot = c.ha + c.hf + c.hs + c.hb;
        vtot = c.va + c.vf + c.vs + c.vb;
        pos  = (k / c.d) % (htot * vtot);
        e_h  = pos % htot;
        e_v  = pos / htot;
        e_en = (k > 0 && e_h < c.ha && e_v < c.va) ? 1 : 0;
        e_pt = (k > 0 && (k % c.d) == c.d - 1) ? 1 : 0;
        e_ls = (k > 0 && (k % c.d) == 0 && e_h == 0) ? 1 : 0;
        e_fs = (e_ls == 1 && e_v == 0) ? 1 : 0;
        ks = k - c.sd;
        hw = 0;
        vw = 0;
        if (ks >= 0) begin
            pos = (ks / c.d) % (htot * vtot);
            hk  = pos % htot;
            vk  = pos / htot;
            hw  = (hk >= c.ha + c.hf && hk < c.ha + c.hf + c.hs) ? 1 : 0;
            vw  = (vk >= c.va + c.vf && vk < c.va + c.vf + c.vs) ? 1 : 0;
        end
        e_hs = hw ? c.pol : 1 - c.pol;
        e_vs = vw ? c.pol : 1 - c.pol;
    endfunction

    task automatic cmp_dut(input string tag, input cfg_t c, input int k,
                           input int h, input int v, input int en, input int pt,
                           input int ls, input int fs, input int hs, input int vs);
        int e_h, e_v, e_en, e_pt, e_ls, e_fs, e_hs, e_vs;
        model(c, k, e_h, e_v, e_en, e_pt, e_ls, e_fs, e_hs, e_vs);
        chk({tag, ".hcount"}, h, e_h);
        chk({tag, ".vcount"}, v, e_v);
        chk({tag, ".enable"}, en, e_en);
        chk({tag, ".pixel_tick"}, pt, e_pt);
        chk({tag, ".line_start"}, ls, e_ls);
        chk({tag, ".frame_start"}, fs, e_fs);
        chk({tag, ".hsync"}, hs, e_hs);
        chk({tag, ".vsync"}, vs, e_vs);
    endtask

    always @(negedge clk) begin
        if (k_a >= 0)
            cmp_dut("a", cfg_a, k_a, int'(hcount_a), int'(vcount_a), int'(en_a), int'(pt_a),
                    int'(ls_a), int'(fs_a), int'(hs_a), int'(vs_a));
        if (k_bc >= 0) begin
            cmp_dut("b", cfg_b, k_bc, int'(hcount_b), int'(vcount_b), int'(en_b), int'(pt_b),
                    int'(ls_b), int'(fs_b), int'(hs_b), int'(vs_b));
            cmp_dut("c", cfg_c, k_bc, int'(hcount_c), int'(vcount_c), int'(en_c), int'(pt_c),
                    int'(ls_c), int'(fs_c), int'(hs_c), int'(vs_c));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n, lo, hi, lines;
        rst_a  = 1'b1;
        rst_bc = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_a  = 1'b0;
        rst_bc = 1'b0;

        // First clock after release.
        step();
        chk("a.k1.hcount", int'(hcount_a), 0);
        chk("a.k1.enable", int'(en_a), 1);
        chk("a.k1.pixel_tick", int'(pt_a), 1);
        chk("a.k1.hsync", int'(hs_a), 1);
        chk("b.k1.hcount", int'(hcount_b), 1);
        chk("c.k1.hcount", int'(hcount_c), 0);

        // One full 640x480 line.
        n = 0;
        while (!ls_a && n < 2000) begin step(); n++; end
        chk("a.first_line_start", int'(ls_a), 1);
        n = 0; lo = 0; hi = 0;
        do begin
            step(); n++;
            if (!hs_a) lo++;
            if (en_a) hi++;
        end while (!ls_a && n < 2000);
        chk("a.line_period", n, 1600);
        chk("a.hsync_low_clocks", lo, 192);
        chk("a.enable_high_clocks", hi, 1280);

        n = 0;
        while (hcount_a != 10'd656 && n < 2000) begin step(); n++; end
        chk("a.reach_h656", int'(hcount_a), 656);
        chk("a.h656_hsync_before", int'(hs_a), 1);
        step();
        chk("a.h656_hsync_after", int'(hs_a), 0);

        // One full small frame on the undivided clock.
        n = 0;
        while (!fs_b && n < 1000) begin step(); n++; end
        chk("b.first_frame_start", int'(fs_b), 1);
        n = 0; lo = 0; lines = 0;
        do begin
            step(); n++;
            if (!vs_b) lo++;
            if (ls_b) lines++;
        end while (!fs_b && n < 1000);
        chk("b.frame_period", n, 425);
        chk("b.vsync_low_clocks", lo, 50);
        chk("b.lines_per_frame", lines, 17);

        // Three-clock sync delay.
        n = 0;
        while (hcount_b != 10'd18 && n < 100) begin step(); n++; end
        chk("b.reach_h18", int'(hcount_b), 18);
        step(); step();
        chk("b.hsync_plus2", int'(hs_b), 1);
        step();
        chk("b.hsync_plus3", int'(hs_b), 0);

        // Single-clock reset mid-frame.
        n = 0;
        while (!(hcount_b == 10'd7 && vcount_b == 10'd5) && n < 500) begin step(); n++; end
        chk("b.reach_7_5", int'(vcount_b), 5);
        rst_bc = 1'b1;
        step();
        chk("b.rst.hcount", int'(hcount_b), 0);
        chk("b.rst.vcount", int'(vcount_b), 0);
        chk("b.rst.hsync", int'(hs_b), 1);
        chk("b.rst.vsync", int'(vs_b), 1);
        chk("b.rst.enable", int'(en_b), 0);
        rst_bc = 1'b0;
        step();
        chk("b.rel1.hcount", int'(hcount_b), 1);
        chk("c.rel1.hcount", int'(hcount_c), 0);
        chk("c.rel1.enable", int'(en_c), 1);
        step();
        chk("c.rel2.pixel_tick", int'(pt_c), 1);
        chk("c.rel2.hcount", int'(hcount_c), 0);
        step();
        chk("c.rel3.hcount", int'(hcount_c), 1);

        // Random run lengths and reset pulses.
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(40, 1200)) step();
            if ($urandom_range(0, 3) == 0) rst_a = 1'b1;
            rst_bc = 1'b1;
            repeat ($urandom_range(1, 3)) step();
            rst_a  = 1'b0;
            rst_bc = 1'b0;
        end
        repeat (300) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
